corner_track: RTL and testbench
===============================

CORNER_TRACK -- requirements
Module: corner_track

Interface
REQ-001 SHALL have parameter X_W, default 10, pixel x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 10, pixel y-coordinate width.
REQ-003 SHALL have parameter MIN_HITS, default 16, minimum detected pixels per frame for a valid result.
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: pix_valid  input  1  pixel qualifier; corner_detected  input  1  per-pixel colour-match flag from the detector.
REQ-007 SHALL have ports: x  input  X_W  pixel column; y  input  Y_W  pixel row.
REQ-008 SHALL have ports: sof  input  1  start-of-frame pulse; eof  input  1  end-of-frame pulse.
REQ-009 SHALL have ports: out_valid  output  1  result valid; out_ready  input  1  consumer accept.
REQ-010 SHALL have ports: tl_x, tr_x, bl_x, br_x  output  X_W each; tl_y, tr_y, bl_y, br_y  output  Y_W each  latched corner coordinates.
REQ-011 SHALL have ports: frame_dropped  output  1  one-cycle pulse; frame_empty  output  1  one-cycle pulse.

Function
REQ-012 SHALL implement states IDLE, ACCUM, EVAL; IDLE->ACCUM on sof; ACCUM->EVAL on eof; EVAL->IDLE after one cycle, or EVAL->ACCUM if sof is high in EVAL.
REQ-013 SHALL count a pixel as a hit when pix_valid && corner_detected in ACCUM, or on the sof cycle that enters/restarts ACCUM.
REQ-014 SHALL compute s = x + y as unsigned X_W+1 bits and d = x - y as signed X_W+1 bits.
REQ-015 SHALL track tl = hit with minimum s, br = maximum s, tr = maximum d, bl = minimum d; strict comparison, first occurrence kept on ties.
REQ-016 SHALL set all four trackers from the first hit of a frame regardless of comparison.
REQ-017 SHALL keep a hit counter of 19 bits, saturating at all-ones, cleared at frame start.
REQ-018 SHALL include a hit on the eof cycle in the closing frame.
REQ-019 SHALL, on sof while in ACCUM, discard the partial frame and restart accumulation, counting the sof-cycle pixel.
REQ-020 SHALL, when sof and eof coincide in ACCUM, close the current frame (eof priority) and start a new frame next cycle via EVAL->ACCUM.
REQ-021 SHALL ignore eof in IDLE and ignore pixels outside ACCUM/sof cycles.
REQ-022 SHALL, in EVAL with hits < MIN_HITS, pulse frame_empty for one cycle and leave outputs unchanged.
REQ-023 SHALL, in EVAL with hits >= MIN_HITS, load outputs and set out_valid the next cycle (eof at cycle N -> out_valid at N+2).
REQ-024 SHALL hold outputs and out_valid stable until out_valid && out_ready; out_valid clears the cycle after transfer.
REQ-025 SHALL, if a result is ready while out_valid && !out_ready, discard the new result and pulse frame_dropped.
REQ-026 SHALL, if a result is ready in the same cycle as a transfer, load it with out_valid staying high and no drop.

Reset
REQ-027 SHALL, on reset low, asynchronously force state IDLE, out_valid 0, frame_dropped 0, frame_empty 0, all corner outputs 0, hit counter 0.
REQ-028 SHALL, on reset asserted mid-frame or mid-handshake, discard all in-flight and pending results; no output pulses follow.

Configuration
REQ-029 SHALL, with CORNER_TRACK_STATS_EN defined, add port out_hits  output  19  hit count of the reported frame, loaded with corners, reset 0.
REQ-030 SHALL, without CORNER_TRACK_STATS_EN, omit out_hits; all other behaviour identical.

Verification
REQ-031 SHALL cover: sof, hits at (100,50),(500,60),(90,400),(520,410) plus 12 hits at (300,200), eof -> tl=(100,50), tr=(500,60), bl=(90,400), br=(520,410), out_valid at eof+2.
REQ-032 SHALL cover: frame with 15 hits, MIN_HITS=16 -> frame_empty pulse, out_valid stays 0.
REQ-033 SHALL cover: two valid frames, out_ready held 0 -> first result held, frame_dropped pulses once at second EVAL; then out_ready=1 -> first result transfers, out_valid drops.
REQ-034 SHALL cover: sof mid-frame after 20 hits at (10,10), then 16 hits at (200,200) and eof -> all corners (200,200); with CORNER_TRACK_STATS_EN, out_hits=16.
REQ-035 SHALL cover: sof and eof same cycle -> closing frame reported, next frame accumulates; reset low mid-ACCUM -> IDLE, out_valid 0, no pulses.

Source files
------------

// File: rtl/corner_track.sv
// ============================================================================
// Module      : corner_track
// Description : Tracks the four extreme corner-coloured pixels of each frame
//               and presents them through a valid/ready result port. Defining
//               CORNER_TRACK_STATS_EN adds the out_hits port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corner_track #(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int MIN_HITS = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_valid,
  input  logic           corner_detected,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           sof,
  input  logic           eof,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] tl_x,
  output logic [X_W-1:0] tr_x,
  output logic [X_W-1:0] bl_x,
  output logic [X_W-1:0] br_x,
  output logic [Y_W-1:0] tl_y,
  output logic [Y_W-1:0] tr_y,
  output logic [Y_W-1:0] bl_y,
  output logic [Y_W-1:0] br_y,
  output logic           frame_dropped,
  output logic           frame_empty
`ifdef CORNER_TRACK_STATS_EN
  ,
  output logic [18:0]    out_hits
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t         state;
  logic           pend_sof;
  logic [18:0]    hits;
  logic [X_W-1:0] tl_x_q, tr_x_q, bl_x_q, br_x_q;
  logic [Y_W-1:0] tl_y_q, tr_y_q, bl_y_q, br_y_q;

  function automatic logic [X_W:0] sum_of(input logic [X_W-1:0] a, input logic [Y_W-1:0] b);
    return {1'b0, a} + (X_W+1)'(b);
  endfunction

  function automatic logic signed [X_W:0] diff_of(input logic [X_W-1:0] a, input logic [Y_W-1:0] b);
    return signed'({1'b0, a} - (X_W+1)'(b));
  endfunction

  logic                  hit;
  logic                  frame_start;
  logic                  accum_hit;
  logic                  result_ok;
  logic                  transfer;
  logic [X_W:0]          s, s_tl, s_br;
  logic signed [X_W:0]   d, d_tr, d_bl;

  assign hit       = pix_valid && corner_detected;
  // A frame opens on sof in IDLE, on a restart sof in ACCUM (unless eof wins),
  // or in EVAL when sof is present now or was deferred by a sof/eof collision.
  assign frame_start = ((state == IDLE) && sof) ||
                       ((state == ACCUM) && sof && !eof) ||
                       ((state == EVAL) && (sof || pend_sof));
  assign accum_hit = (state == ACCUM) && hit && !frame_start;
  assign result_ok = hits >= 19'(MIN_HITS);
  assign transfer  = out_valid && out_ready;

  assign s    = sum_of(x, y);
  assign d    = diff_of(x, y);
  assign s_tl = sum_of(tl_x_q, tl_y_q);
  assign s_br = sum_of(br_x_q, br_y_q);
  assign d_tr = diff_of(tr_x_q, tr_y_q);
  assign d_bl = diff_of(bl_x_q, bl_y_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pend_sof      <= 1'b0;
      hits          <= '0;
      tl_x_q <= '0; tr_x_q <= '0; bl_x_q <= '0; br_x_q <= '0;
      tl_y_q <= '0; tr_y_q <= '0; bl_y_q <= '0; br_y_q <= '0;
      out_valid     <= 1'b0;
      frame_dropped <= 1'b0;
      frame_empty   <= 1'b0;
      tl_x <= '0; tr_x <= '0; bl_x <= '0; br_x <= '0;
      tl_y <= '0; tr_y <= '0; bl_y <= '0; br_y <= '0;
`ifdef CORNER_TRACK_STATS_EN
      out_hits      <= '0;
`endif
    end else begin
      frame_dropped <= 1'b0;
      frame_empty   <= 1'b0;
      if (transfer) out_valid <= 1'b0;

      case (state)
        IDLE:  if (sof) state <= ACCUM;
        ACCUM: if (eof) begin
          state    <= EVAL;
          pend_sof <= sof;
        end
        EVAL: begin
          state    <= (sof || pend_sof) ? ACCUM : IDLE;
          pend_sof <= 1'b0;
          if (!result_ok) begin
            frame_empty <= 1'b1;
          end else if (!out_valid || transfer) begin
            out_valid <= 1'b1;
            tl_x <= tl_x_q; tr_x <= tr_x_q; bl_x <= bl_x_q; br_x <= br_x_q;
            tl_y <= tl_y_q; tr_y <= tr_y_q; bl_y <= bl_y_q; br_y <= br_y_q;
`ifdef CORNER_TRACK_STATS_EN
            out_hits <= hits;
`endif
          end else begin
            frame_dropped <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Trackers are read by the EVAL load above before a new frame overwrites them.
      if (frame_start) begin
        hits <= hit ? 19'd1 : 19'd0;
        if (hit) begin
          tl_x_q <= x; tr_x_q <= x; bl_x_q <= x; br_x_q <= x;
          tl_y_q <= y; tr_y_q <= y; bl_y_q <= y; br_y_q <= y;
        end
      end else if (accum_hit) begin
        if (hits != '1) hits <= hits + 19'd1;
        if (hits == '0) begin
          tl_x_q <= x; tr_x_q <= x; bl_x_q <= x; br_x_q <= x;
          tl_y_q <= y; tr_y_q <= y; bl_y_q <= y; br_y_q <= y;
        end else begin
          if (s < s_tl) begin tl_x_q <= x; tl_y_q <= y; end
          if (s > s_br) begin br_x_q <= x; br_y_q <= y; end
          if (d > d_tr) begin tr_x_q <= x; tr_y_q <= y; end
          if (d < d_bl) begin bl_x_q <= x; bl_y_q <= y; end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_corner_track.sv
// ============================================================================
// Module      : tb_corner_track
// Description : Directed scoreboard bench for corner_track.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corner_track;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid, corner_detected, sof, eof, out_ready;
  logic [9:0] x, y;
  logic       out_valid, frame_dropped, frame_empty;
  logic [9:0] tl_x, tr_x, bl_x, br_x, tl_y, tr_y, bl_y, br_y;
`ifdef CORNER_TRACK_STATS_EN
  logic [18:0] out_hits;
`endif

  corner_track #(.X_W(10), .Y_W(10), .MIN_HITS(16)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .corner_detected(corner_detected),
    .x(x), .y(y), .sof(sof), .eof(eof), .out_valid(out_valid), .out_ready(out_ready),
    .tl_x(tl_x), .tr_x(tr_x), .bl_x(bl_x), .br_x(br_x),
    .tl_y(tl_y), .tr_y(tr_y), .bl_y(bl_y), .br_y(br_y),
    .frame_dropped(frame_dropped), .frame_empty(frame_empty)
`ifdef CORNER_TRACK_STATS_EN
    , .out_hits(out_hits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tlx, tly, trx, tr_y_e, blx, bly, brx, bry, nh;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   empty_cnt = 0;
  int   drop_cnt = 0;
  int   e0, d0;

  always @(posedge clk) begin
    if (frame_empty === 1'b1) empty_cnt++;
    if (frame_dropped === 1'b1) drop_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic cd, input logic s, input logic e,
                       input int px, input int py);
    pix_valid = pv; corner_detected = cd; sof = s; eof = e;
    x = px[9:0]; y = py[9:0];
    tick();
    pix_valid = 1'b0; corner_detected = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic hit_px(input int px, input int py, input logic e);
    drive(1'b1, 1'b1, 1'b0, e, px, py);
  endtask

  // sof without a pixel, then n hits at one coordinate, eof on the last
  task automatic uniform_frame(input int px, input int py, input int n);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (n - 1) hit_px(px, py, 1'b0);
    hit_px(px, py, 1'b1);
  endtask

  task automatic push_res(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int g, input int h, input int n);
    res_t r;
    r.tlx = a; r.tly = b; r.trx = c; r.tr_y_e = d;
    r.blx = e; r.bly = f; r.brx = g; r.bry = h; r.nh = n;
    exp_q.push_back(r);
  endtask

  task automatic check_result(input string tag);
    res_t r;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, ".tl_x"}, 32'(tl_x), r.tlx);
      chk({tag, ".tl_y"}, 32'(tl_y), r.tly);
      chk({tag, ".tr_x"}, 32'(tr_x), r.trx);
      chk({tag, ".tr_y"}, 32'(tr_y), r.tr_y_e);
      chk({tag, ".bl_x"}, 32'(bl_x), r.blx);
      chk({tag, ".bl_y"}, 32'(bl_y), r.bly);
      chk({tag, ".br_x"}, 32'(br_x), r.brx);
      chk({tag, ".br_y"}, 32'(br_y), r.bry);
`ifdef CORNER_TRACK_STATS_EN
      chk({tag, ".out_hits"}, 32'(out_hits), r.nh);
`endif
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_cleared"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0;
    pix_valid = 1'b0; corner_detected = 1'b0; sof = 1'b0; eof = 1'b0; x = '0; y = '0;
    tick(); tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.frame_empty", 32'(frame_empty), 32'd0);
    chk("rst.frame_dropped", 32'(frame_dropped), 32'd0);
    chk("rst.tl_x", 32'(tl_x), 32'd0);
    chk("rst.br_y", 32'(br_y), 32'd0);
    reset = 1'b1;
    tick();

    // basic frame with four distinct corners; IDLE pixel/eof and unqualified pixels ignored
    hit_px(0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    hit_px(100, 50, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    hit_px(500, 60, 1'b0);
    hit_px(90, 400, 1'b0);
    hit_px(520, 410, 1'b0);
    repeat (11) hit_px(300, 200, 1'b0);
    hit_px(300, 200, 1'b1);
    push_res(100, 50, 500, 60, 90, 400, 520, 410, 16);
    chk("t1.valid_at_eof1", 32'(out_valid), 32'd0);
    tick();
    check_result("t1");
    repeat (3) tick();
    chk("t1.hold_valid", 32'(out_valid), 32'd1);
    chk("t1.hold_tl_x", 32'(tl_x), 32'd100);
    chk("t1.no_empty", 32'(empty_cnt), 32'd0);
    accept("t1");

    // 15 hits (sof-cycle hit counted) -> empty; 16 hits -> valid, ties keep first
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5, 5);
    repeat (13) hit_px(40, 40, 1'b0);
    hit_px(40, 40, 1'b1);
    tick();
    chk("t2.frame_empty", 32'(frame_empty), 32'd1);
    chk("t2.no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t2.empty_one_cycle", 32'(frame_empty), 32'd0);
    chk("t2.empty_cnt", 32'(empty_cnt), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5, 5);
    repeat (14) hit_px(50, 50, 1'b0);
    hit_px(50, 50, 1'b1);
    push_res(5, 5, 5, 5, 5, 5, 50, 50, 16);
    tick();
    check_result("t2b");
    accept("t2b");

    // back-pressure: second result dropped, first held
    d0 = drop_cnt;
    uniform_frame(11, 22, 16);
    push_res(11, 22, 11, 22, 11, 22, 11, 22, 16);
    tick();
    check_result("t3a");
    uniform_frame(33, 44, 20);
    tick();
    chk("t3.frame_dropped", 32'(frame_dropped), 32'd1);
    chk("t3.held_tl_x", 32'(tl_x), 32'd11);
    chk("t3.held_br_y", 32'(br_y), 32'd22);
    tick();
    chk("t3.drop_cnt", 32'(drop_cnt), 32'(d0 + 1));
    chk("t3.still_valid", 32'(out_valid), 32'd1);
    accept("t3");

    // transfer and new load in the same cycle
    d0 = drop_cnt;
    uniform_frame(1, 2, 16);
    push_res(1, 2, 1, 2, 1, 2, 1, 2, 16);
    tick();
    check_result("t4a");
    uniform_frame(3, 4, 16);
    push_res(3, 4, 3, 4, 3, 4, 3, 4, 16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_result("t4b");
    tick();
    chk("t4.no_drop", 32'(drop_cnt), 32'(d0));
    accept("t4");

    // restart mid-frame discards the partial frame
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (20) hit_px(10, 10, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (15) hit_px(200, 200, 1'b0);
    hit_px(200, 200, 1'b1);
    push_res(200, 200, 200, 200, 200, 200, 200, 200, 16);
    tick();
    check_result("t5");
    accept("t5");

    // sof and eof together: closing frame reported, next frame accumulates
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (15) hit_px(7, 8, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 7, 8);
    push_res(7, 8, 7, 8, 7, 8, 7, 8, 16);
    tick();
    check_result("t6a");
    accept("t6a");
    repeat (15) hit_px(60, 70, 1'b0);
    hit_px(60, 70, 1'b1);
    push_res(60, 70, 60, 70, 60, 70, 60, 70, 16);
    tick();
    check_result("t6b");
    accept("t6b");

    // reset mid-frame with a result pending
    uniform_frame(9, 9, 16);
    push_res(9, 9, 9, 9, 9, 9, 9, 9, 16);
    tick();
    check_result("t7a");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (10) hit_px(1, 1, 1'b0);
    reset = 1'b0;
    #2;
    chk("t7.async_valid", 32'(out_valid), 32'd0);
    chk("t7.async_tl_x", 32'(tl_x), 32'd0);
    tick();
    reset = 1'b1;
    e0 = empty_cnt; d0 = drop_cnt;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (4) tick();
    chk("t7.no_empty", 32'(empty_cnt), 32'(e0));
    chk("t7.no_drop", 32'(drop_cnt), 32'(d0));
    chk("t7.out_valid", 32'(out_valid), 32'd0);
    chk("t7.tl_y", 32'(tl_y), 32'd0);
    chk("end.scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
